// File: rtl/vga_fb_scan.sv
// vga_fb_scan: clamps the timing generator's active window to H_PIX x V_PIX, scans a framebuffer, and drives RGB/sync with 2-cycle latency.
// Optional test pattern generator (8 vertical colour bars) enabled by defining VGA_FB_TEST_PATTERN_EN.
module vga_fb_scan #(
  parameter int H_PIX  = 640,
  parameter int V_PIX  = 480,
  parameter int PIX_W  = 3,
  parameter int ADDR_W = $clog2(H_PIX*V_PIX)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hs_i,
  input  logic              vs_i,
  input  logic              hs_valid_i,
  input  logic              vs_valid_i,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [PIX_W-1:0]  fb_rd_data,
  output logic              hs_o,
  output logic              vs_o,
  output logic              de_o,
  output logic [PIX_W-1:0]  rgb_o,
  output logic              frame_done_o
`ifdef VGA_FB_TEST_PATTERN_EN
  ,
  input  logic              test_en
`endif
);
  localparam int XW = $clog2(H_PIX+1);
  localparam int YW = $clog2(V_PIX+1);
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [ADDR_W-1:0] addr;
  logic armed, hs_valid_q, vs_valid_q, active, y_inc;
  logic act_d1, hs_d1, vs_d1;
  logic [PIX_W-1:0] pix;
  // armed stays low after reset until a vertical blank, so a mid-frame reset resumes at the next frame
  assign active = armed & hs_valid_i & vs_valid_i & (x < XW'(H_PIX)) & (y < YW'(V_PIX));
  assign y_inc = armed & hs_valid_q & ~hs_valid_i & vs_valid_q & (x != '0) & (y < YW'(V_PIX));
  assign fb_rd_addr = addr;
`ifdef VGA_FB_TEST_PATTERN_EN
  localparam int BAR_W = H_PIX/8;
  logic tp_d1;
  logic [2:0] bar_d1;
  assign fb_rd_en = active & ~test_en;
  assign pix = tp_d1 ? PIX_W'(bar_d1) : fb_rd_data;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp_d1  <= 1'b0;
      bar_d1 <= '0;
    end else begin
      tp_d1  <= test_en;
      bar_d1 <= 3'(x / XW'(BAR_W));
    end
  end
`else
  assign fb_rd_en = active;
  assign pix = fb_rd_data;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      hs_valid_q   <= 1'b0;
      vs_valid_q   <= 1'b0;
      x            <= '0;
      y            <= '0;
      addr         <= '0;
      frame_done_o <= 1'b0;
      act_d1       <= 1'b0;
      hs_d1        <= 1'b1;
      vs_d1        <= 1'b1;
      de_o         <= 1'b0;
      hs_o         <= 1'b1;
      vs_o         <= 1'b1;
      rgb_o        <= '0;
    end else begin
      armed        <= armed | ~vs_valid_i;
      hs_valid_q   <= hs_valid_i;
      vs_valid_q   <= vs_valid_i;
      x            <= !hs_valid_i ? '0 : active ? x + 1'b1 : x;
      y            <= !vs_valid_i ? '0 : y_inc ? y + 1'b1 : y;
      addr         <= !vs_valid_i ? '0 : active ? addr + 1'b1 : addr;
      frame_done_o <= y_inc & (y == YW'(V_PIX-1));
      act_d1       <= active;
      hs_d1        <= hs_i;
      vs_d1        <= vs_i;
      de_o         <= act_d1;
      hs_o         <= hs_d1;
      vs_o         <= vs_d1;
      rgb_o        <= act_d1 ? pix : '0;
    end
  end
endmodule

// File: tb/tb_vga_fb_scan.sv
// tb_vga_fb_scan: directed bench for vga_fb_scan at a reduced 16x8 raster with a RAM returning addr[2:0].
module tb_vga_fb_scan;
  localparam int H = 16, V = 8, AW = 7, HV = 20;
  logic clk = 0, rst_n = 0, hs_i = 1, vs_i = 1, hs_valid_i = 0, vs_valid_i = 0;
  logic fb_rd_en, hs_o, vs_o, de_o, frame_done_o;
  logic [AW-1:0] fb_rd_addr;
  logic [2:0] fb_rd_data = '0, rgb_o;
`ifdef VGA_FB_TEST_PATTERN_EN
  logic test_en = 0;
`endif
  int checks = 0, errors = 0;
  int de_cnt = 0, rd_cnt = 0, fd_cnt = 0, runs = 0, run_len = 0, run_min = 1000, run_max = 0;
  int align_err = 0, pat_err = 0, cyc = 0, fall_cyc = 0, fd_gap = -1;
  logic [AW-1:0] last_addr = '0, first_addr = '1, a_d1 = '0, a_d2 = '0;
  bit rd_seen = 0, hv_prev = 0, r1 = 0, r2 = 0, tp = 0;
  logic en_d1 = 0, en_d2 = 0, hs_d1 = 1, hs_d2 = 1, vs_d1 = 1, vs_d2 = 1;

  always #5 clk = ~clk;

  vga_fb_scan #(.H_PIX(H), .V_PIX(V), .PIX_W(3), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .hs_i(hs_i), .vs_i(vs_i),
    .hs_valid_i(hs_valid_i), .vs_valid_i(vs_valid_i),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .hs_o(hs_o), .vs_o(vs_o), .de_o(de_o), .rgb_o(rgb_o), .frame_done_o(frame_done_o)
`ifdef VGA_FB_TEST_PATTERN_EN
    , .test_en(test_en)
`endif
  );

  always @(posedge clk) if (fb_rd_en) fb_rd_data <= fb_rd_addr[2:0];

  // Monitor: counts, de_o run lengths, and an independent 2-cycle pipeline model
  always @(negedge clk) begin
    cyc++;
    if (hv_prev && !hs_valid_i) fall_cyc = cyc;
    hv_prev = hs_valid_i;
    if (frame_done_o) begin fd_cnt++; fd_gap = cyc - fall_cyc; end
    if (fb_rd_en) begin
      rd_cnt++;
      last_addr = fb_rd_addr;
      if (!rd_seen) first_addr = fb_rd_addr;
      rd_seen = 1;
    end
    if (!vs_valid_i) rd_seen = 0;
    if (de_o) begin
      if (tp && rgb_o !== 3'(run_len / 2)) pat_err++;
      de_cnt++;
      run_len++;
    end else if (run_len > 0) begin
      runs++;
      if (run_len < run_min) run_min = run_len;
      if (run_len > run_max) run_max = run_len;
      run_len = 0;
    end
    if (rst_n && r1 && r2 && !tp)
      if (de_o !== en_d2 || hs_o !== hs_d2 || vs_o !== vs_d2 || (de_o && rgb_o !== a_d2[2:0])) align_err++;
    en_d2 = en_d1; en_d1 = fb_rd_en;
    a_d2 = a_d1; a_d1 = fb_rd_addr;
    hs_d2 = hs_d1; hs_d1 = hs_i;
    vs_d2 = vs_d1; vs_d1 = vs_i;
    r2 = r1; r1 = rst_n;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic blank;
    hs_valid_i = 0; tick();
    hs_i = 0; tick(); tick();
    hs_i = 1; tick(); tick(); tick();
  endtask

  task automatic line(input int hv_len, input bit vsv);
    vs_valid_i = vsv; hs_valid_i = 1; hs_i = 1;
    repeat (hv_len) tick();
    blank();
  endtask

  task automatic preamble;
    vs_i = 0; line(HV, 0);
    vs_i = 1; line(HV, 0); line(HV, 0);
  endtask

  task automatic frame(input int n);
    preamble();
    repeat (n) line(HV, 1);
  endtask

  task automatic test_reset;
    rst_n = 0; tick(); tick();
    checks += 7;
    if (fb_rd_en !== 0) begin errors++; $display("FAIL reset fb_rd_en got %0b exp 0", fb_rd_en); end
    if (fb_rd_addr !== 0) begin errors++; $display("FAIL reset fb_rd_addr got %0d exp 0", fb_rd_addr); end
    if (de_o !== 0) begin errors++; $display("FAIL reset de_o got %0b exp 0", de_o); end
    if (rgb_o !== 0) begin errors++; $display("FAIL reset rgb_o got %0d exp 0", rgb_o); end
    if (frame_done_o !== 0) begin errors++; $display("FAIL reset frame_done got %0b exp 0", frame_done_o); end
    if (hs_o !== 1) begin errors++; $display("FAIL reset hs_o got %0b exp 1", hs_o); end
    if (vs_o !== 1) begin errors++; $display("FAIL reset vs_o got %0b exp 1", vs_o); end
    rst_n = 1; tick();
  endtask

  task automatic test_full_frame;
    int d0, r0, f0, n0;
    d0 = de_cnt; r0 = rd_cnt; f0 = fd_cnt; n0 = runs;
    frame(V + 2);
    checks += 10;
    if (de_cnt - d0 !== H*V) begin errors++; $display("FAIL frame de count got %0d exp %0d", de_cnt - d0, H*V); end
    if (rd_cnt - r0 !== H*V) begin errors++; $display("FAIL frame rd count got %0d exp %0d", rd_cnt - r0, H*V); end
    if (runs - n0 !== V) begin errors++; $display("FAIL frame lines got %0d exp %0d", runs - n0, V); end
    if (run_min !== H) begin errors++; $display("FAIL frame min line got %0d exp %0d", run_min, H); end
    if (run_max !== H) begin errors++; $display("FAIL frame max line got %0d exp %0d", run_max, H); end
    if (first_addr !== 0) begin errors++; $display("FAIL frame first addr got %0d exp 0", first_addr); end
    if (last_addr !== H*V-1) begin errors++; $display("FAIL frame last addr got %0d exp %0d", last_addr, H*V-1); end
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL frame done pulses got %0d exp 1", fd_cnt - f0); end
    if (fd_gap !== 1) begin errors++; $display("FAIL frame done gap got %0d exp 1", fd_gap); end
    if (align_err !== 0) begin errors++; $display("FAIL frame alignment errors got %0d exp 0", align_err); end
  endtask

  task automatic test_align;
    preamble();
    vs_valid_i = 1; hs_valid_i = 1; hs_i = 1;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 0 || c == 5) begin
        checks++;
        if (fb_rd_en !== 1 || fb_rd_addr !== AW'(c)) begin errors++; $display("FAIL align issue c=%0d got en=%0b addr=%0d exp en=1 addr=%0d", c, fb_rd_en, fb_rd_addr, c); end
      end
      if (c == 2 || c == 7) begin
        checks++;
        if (de_o !== 1 || rgb_o !== 3'(c - 2)) begin errors++; $display("FAIL align data c=%0d got de=%0b rgb=%0d exp de=1 rgb=%0d", c, de_o, rgb_o, c - 2); end
      end
      tick();
    end
    repeat (HV - 10) tick();
    hs_valid_i = 0; tick();
    hs_i = 0; tick();
    checks++;
    if (hs_o !== 1) begin errors++; $display("FAIL align hs_o at N+1 got %0b exp 1", hs_o); end
    tick();
    checks++;
    if (hs_o !== 0) begin errors++; $display("FAIL align hs_o at N+2 got %0b exp 0", hs_o); end
    hs_i = 1; tick(); tick(); tick();
    repeat (V + 1) line(HV, 1);
  endtask

  task automatic test_truncated;
    int d0, f0;
    d0 = de_cnt; f0 = fd_cnt;
    frame(4);
    vs_valid_i = 0; line(HV, 0);
    checks += 2;
    if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL truncated done pulses got %0d exp 0", fd_cnt - f0); end
    if (de_cnt - d0 !== 4*H) begin errors++; $display("FAIL truncated de count got %0d exp %0d", de_cnt - d0, 4*H); end
  endtask

  task automatic test_hs_glitch;
    int r0, f0;
    r0 = rd_cnt; f0 = fd_cnt;
    preamble();
    vs_valid_i = 1; hs_valid_i = 1;
    repeat (5) tick();
    hs_valid_i = 0; tick();
    hs_valid_i = 1; #1;
    checks++;
    if (fb_rd_en !== 1 || fb_rd_addr !== 5) begin errors++; $display("FAIL glitch resume got en=%0b addr=%0d exp en=1 addr=5", fb_rd_en, fb_rd_addr); end
    repeat (HV) tick();
    blank();
    repeat (V + 1) line(HV, 1);
    checks += 4;
    if (rd_cnt - r0 !== 5 + 7*H) begin errors++; $display("FAIL glitch rd count got %0d exp %0d", rd_cnt - r0, 5 + 7*H); end
    if (last_addr !== 4 + 7*H) begin errors++; $display("FAIL glitch last addr got %0d exp %0d", last_addr, 4 + 7*H); end
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL glitch done pulses got %0d exp 1", fd_cnt - f0); end
    if (align_err !== 0) begin errors++; $display("FAIL glitch alignment errors got %0d exp 0", align_err); end
  endtask

  task automatic test_reset_mid;
    int d0, r0, f0;
    preamble();
    repeat (3) line(HV, 1);
    vs_valid_i = 1; hs_valid_i = 1;
    repeat (5) tick();
    rst_n = 0; #1;
    checks += 6;
    if (fb_rd_en !== 0) begin errors++; $display("FAIL midreset fb_rd_en got %0b exp 0", fb_rd_en); end
    if (fb_rd_addr !== 0) begin errors++; $display("FAIL midreset fb_rd_addr got %0d exp 0", fb_rd_addr); end
    if (de_o !== 0) begin errors++; $display("FAIL midreset de_o got %0b exp 0", de_o); end
    if (rgb_o !== 0) begin errors++; $display("FAIL midreset rgb_o got %0d exp 0", rgb_o); end
    if (hs_o !== 1 || vs_o !== 1) begin errors++; $display("FAIL midreset syncs got hs=%0b vs=%0b exp 1 1", hs_o, vs_o); end
    if (frame_done_o !== 0) begin errors++; $display("FAIL midreset frame_done got %0b exp 0", frame_done_o); end
    repeat (3) tick();
    rst_n = 1;
    d0 = de_cnt; r0 = rd_cnt; f0 = fd_cnt;
    repeat (HV - 8) tick();
    blank();
    repeat (6) line(HV, 1);
    checks += 3;
    if (de_cnt - d0 !== 0) begin errors++; $display("FAIL midreset de after release got %0d exp 0", de_cnt - d0); end
    if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL midreset rd after release got %0d exp 0", rd_cnt - r0); end
    if (fd_cnt - f0 !== 0) begin errors++; $display("FAIL midreset done pulses got %0d exp 0", fd_cnt - f0); end
    r0 = rd_cnt; f0 = fd_cnt;
    frame(V + 2);
    checks += 3;
    if (first_addr !== 0) begin errors++; $display("FAIL midreset restart addr got %0d exp 0", first_addr); end
    if (rd_cnt - r0 !== H*V) begin errors++; $display("FAIL midreset next frame rd got %0d exp %0d", rd_cnt - r0, H*V); end
    if (fd_cnt - f0 !== 1) begin errors++; $display("FAIL midreset next frame done got %0d exp 1", fd_cnt - f0); end
  endtask

`ifdef VGA_FB_TEST_PATTERN_EN
  task automatic test_pattern;
    int d0, r0, p0;
    d0 = de_cnt; r0 = rd_cnt; p0 = pat_err;
    tp = 1; test_en = 1;
    frame(V + 2);
    test_en = 0; tick(); tick(); tick();
    tp = 0;
    checks += 3;
    if (rd_cnt - r0 !== 0) begin errors++; $display("FAIL pattern rd count got %0d exp 0", rd_cnt - r0); end
    if (de_cnt - d0 !== H*V) begin errors++; $display("FAIL pattern de count got %0d exp %0d", de_cnt - d0, H*V); end
    if (pat_err - p0 !== 0) begin errors++; $display("FAIL pattern bar errors got %0d exp 0", pat_err - p0); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_frame();
    test_align();
    test_truncated();
    test_hs_glitch();
    test_reset_mid();
`ifdef VGA_FB_TEST_PATTERN_EN
    test_pattern();
`endif
    vs_valid_i = 0; line(HV, 0);
    checks++;
    if (align_err !== 0) begin errors++; $display("FAIL final alignment errors got %0d exp 0", align_err); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_fb_scan.md
# vga_fb_scan

Framebuffer scan-out stage directly downstream of the VGA timing generator. It consumes the generator's sync and valid strobes and clamps the active window to exactly H_PIX × V_PIX. It issues linear read addresses to a synchronous-read framebuffer RAM and drives registered RGB plus sync outputs, aligned with a fixed 2-cycle latency. It also flags end-of-frame so the framebuffer writer can swap buffers.

## Interface
Parameters:
- H_PIX, 640, active pixels per line
- V_PIX, 480, active lines per frame
- PIX_W, 3, bits per pixel (RGB packed)
- ADDR_W, $clog2(H_PIX*V_PIX), framebuffer address width (19 at defaults)

Ports:
- clk  in  1  pixel clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- hs_i  in  1  horizontal sync from timing generator, low during pulse
- vs_i  in  1  vertical sync from timing generator, low during pulse
- hs_valid_i  in  1  high after horizontal sync+back porch, through end of line; no upper bound
- vs_valid_i  in  1  high after vertical sync+back porch, through end of frame; no upper bound
- fb_rd_en  out  1  framebuffer read strobe
- fb_rd_addr  out  ADDR_W  linear read address, y*H_PIX+x
- fb_rd_data  in  PIX_W  RAM data, valid exactly 1 cycle after fb_rd_en
- hs_o  out  1  hs_i delayed 2 cycles
- vs_o  out  1  vs_i delayed 2 cycles
- de_o  out  1  data enable, aligned with rgb_o
- rgb_o  out  PIX_W  pixel out, 0 when de_o low
- frame_done_o  out  1  one-cycle pulse after last active pixel of a frame
- test_en  in  1  present only with VGA_FB_TEST_PATTERN_EN

## Operation
- Stage 0 (comb + regs): active = hs_valid_i & vs_valid_i & (x < H_PIX) & (y < V_PIX). The valid inputs overrun the active area; clamping is this block's job.
- x counter: increments on each active cycle. Forced to 0 whenever hs_valid_i is low. Stops at H_PIX; never wraps within a line.
- y counter: increments on a registered falling edge of hs_valid_i (hs_valid_q & ~hs_valid_i) when vs_valid_q was high and x ≠ 0. Saturates at V_PIX. Forced to 0 whenever vs_valid_i is low.
- Address counter: increments on each active cycle. Cleared when vs_valid_i is low. Not derived by multiplication.
- fb_rd_en = active; fb_rd_addr = address counter value for that pixel.
- Stage 1: RAM access. active, hs_i, vs_i and bar index are delayed 1 cycle.
- Stage 2: registered rgb_o = fb_rd_data when the delayed active is high, else 0. de_o, hs_o and vs_o are registered from the same delay line.
- frame_done_o: pulses when y reaches V_PIX, i.e. one cycle after the y increment that ends line V_PIX-1. Pulses once per frame. A frame truncated by vs_valid_i falling early produces no pulse.
- Upstream restart mid-line: a low hs_valid_i or vs_valid_i immediately clears the corresponding counters. No stale-state recovery is needed.

## Timing
- Reset (async assert, sync use after deassert): x=0, y=0, addr=0, fb_rd_en=0, fb_rd_addr=0, rgb_o=0, de_o=0, frame_done_o=0, hs_o=1, vs_o=1. All delay-line stages reset to the same inactive values.
- Latency: input strobes at cycle N produce hs_o/vs_o/de_o/rgb_o at cycle N+2. Sync-to-data alignment is preserved exactly.
- fb_rd_en to data: 1 cycle. RAM must be synchronous-read with no output register.
- First active cycle of a frame: fb_rd_addr=0. Last: fb_rd_addr=H_PIX*V_PIX-1.
- Reset asserted mid-frame: outputs go inactive immediately. After release, the block waits for vs_valid_i low. Active output restarts at the next frame.
- Boundary: cycle H_PIX+1 of a long hs_valid_i window gives de_o=0. Line V_PIX+1 of a long vs_valid_i window gives no reads.

## Configuration
- VGA_FB_TEST_PATTERN_EN defined: port test_en exists. When test_en=1, fb_rd_en is held 0. rgb_o shows 8 vertical colour bars of width H_PIX/8, with value = bar index (0..7) in the low 3 bits and upper bits 0. Bar index comes from x, pipelined to stage 2. PIX_W ≥ 3 is required. test_en is sampled per pixel; toggling it mid-line switches source at that pixel +2 cycles.
- Not defined: no test_en port and no pattern logic. rgb_o always comes from fb_rd_data.

## Test plan
- Upstream timing (hs_valid 664 cycles/line, vs_valid 489 lines) with RAM model data=addr[2:0]. Required: exactly 640 de_o cycles per line, 480 lines, 307200 fb_rd_en per frame, last fb_rd_addr=307199.
- Alignment: hs_i falling at cycle N gives hs_o falling at N+2. The first de_o of line 0 has rgb_o=0. The pixel at address 5 shows rgb_o=5 two cycles after issue.
- frame_done_o: exactly one pulse per frame, 1 cycle after line 479 ends; zero pulses when vs_valid_i drops after line 100.
- rst_n low at line 200, pixel 300, for 3 cycles. Required: outputs immediately at reset values, no de_o until the next vs_valid_i rise, then fb_rd_addr restarts at 0.
- VGA_FB_TEST_PATTERN_EN with test_en=1. Required: fb_rd_en=0 all frame; rgb_o=0 for x 0..79, 1 for x 80..159, … 7 for x 560..639.
- hs_valid_i low for one cycle at x=100 mid-line. Required: x clears to 0, y increments by 1, addr continues without reset.
